// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The requester drives i_valid/i_bin; the converter returns readiness and the BCD digits.
interface bin_to_bcd_seq_if #(
  parameter int W = 13
);
  logic         i_valid;
  logic [W-1:0] i_bin;
  logic         o_ready;
  logic         o_busy;
  logic [3:0]   o_thousands;
  logic [3:0]   o_hundreds;
  logic [3:0]   o_tens;
  logic [3:0]   o_ones;
  logic         o_done;
  logic         o_changed;

  modport master (
    output i_valid, i_bin,
    input  o_ready, o_busy, o_thousands, o_hundreds, o_tens, o_ones, o_done, o_changed
  );

  modport slave (
    input  i_valid, i_bin,
    output o_ready, o_busy, o_thousands, o_hundreds, o_tens, o_ones, o_done, o_changed
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per clock, W clocks per conversion,
// four registered BCD digits plus done/changed pulses.
module bin_to_bcd_seq #(
  parameter int W = 13
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  bin_to_bcd_seq_if.slave  bus
);
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [W-1:0]     shift_r, shift_s;
  logic [15:0]      scratch_r, scratch_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [15:0]      digits_r, digits_s;
  logic             done_r, done_s;
  logic             changed_r, changed_s;
  logic             ready_r, ready_s;
  logic [15:0]      step_s;

  // One double-dabble step: correct every digit >= 5, then shift the next binary bit in.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    adj = bcd;
    for (int d = 0; d < 4; d++) begin
      if (adj[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end else begin
        adj[4*d +: 4] = adj[4*d +: 4];
      end
    end
    return {adj[14:0], bit_in};
  endfunction

  // Next-state and datapath decode.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    scratch_s = scratch_r;
    cnt_s     = cnt_r;
    digits_s  = digits_r;
    done_s    = 1'b0;
    changed_s = 1'b0;
    step_s    = dabble_step(scratch_r, shift_r[W-1]);
    case (state_r)
      IDLE: begin
        if (bus.i_valid) begin
          shift_s   = bus.i_bin;
          scratch_s = 16'd0;
          cnt_s     = CNT_W'(W);
          state_s   = SHIFT;
        end else begin
          state_s   = IDLE;
        end
      end
      SHIFT: begin
        scratch_s = step_s;
        shift_s   = shift_r << 1;
        cnt_s     = cnt_r - 4'd1;
        // The step taken with one bit left completes the conversion.
        if (cnt_r == 4'd1) begin
          digits_s  = step_s;
          done_s    = 1'b1;
          changed_s = (step_s != digits_r);
          state_s   = IDLE;
        end else begin
          state_s   = SHIFT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    ready_s = (state_s == IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      shift_r   <= {W{1'b0}};
      scratch_r <= 16'd0;
      cnt_r     <= {CNT_W{1'b0}};
      digits_r  <= 16'd0;
      done_r    <= 1'b0;
      changed_r <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      scratch_r <= scratch_s;
      cnt_r     <= cnt_s;
      digits_r  <= digits_s;
      done_r    <= done_s;
      changed_r <= changed_s;
      ready_r   <= ready_s;
    end
  end

  assign bus.o_ready     = ready_r;
  assign bus.o_busy      = ~ready_r;
  assign bus.o_thousands = digits_r[15:12];
  assign bus.o_hundreds  = digits_r[11:8];
  assign bus.o_tens      = digits_r[7:4];
  assign bus.o_ones      = digits_r[3:0];
  assign bus.o_done      = done_r;
  assign bus.o_changed   = changed_r;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq with an arithmetic reference model
// and directed scenarios pinned by hand-computed expectations.
module tb_bin_to_bcd_seq;
  localparam int W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.W(W)) bus();
  bin_to_bcd_seq #(.W(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: cycles left busy, captured value, expected outputs.
  int           m_rem = 0;
  logic [W-1:0] m_val;
  logic [15:0]  m_dig;
  logic         m_done, m_chg;
  bit           check_en = 1'b0;
  time          last_done_t;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_digits();
    return {bus.o_thousands, bus.o_hundreds, bus.o_tens, bus.o_ones};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem    <= 0;
      m_dig    <= 16'h0000;
      m_done   <= 1'b0;
      m_chg    <= 1'b0;
      check_en <= 1'b1;
    end else begin
      m_done <= 1'b0;
      m_chg  <= 1'b0;
      if (m_rem == 0) begin
        if (bus.i_valid) begin
          m_val <= bus.i_bin;
          m_rem <= W;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_dig  <= to_bcd(int'(m_val));
          m_chg  <= (to_bcd(int'(m_val)) != m_dig);
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("ready",   32'(bus.o_ready),  32'(m_rem == 0));
      chk("busy",    32'(bus.o_busy),   32'(m_rem != 0));
      chk("digits",  32'(dut_digits()), 32'(m_dig));
      chk("done",    32'(bus.o_done),   32'(m_done));
      chk("changed", 32'(bus.o_changed), 32'(m_chg));
      chk("digit_range", 32'(bus.o_thousands <= 4'd9 && bus.o_hundreds <= 4'd9 &&
                             bus.o_tens <= 4'd9 && bus.o_ones <= 4'd9), 32'd1);
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic convert(input logic [W-1:0] v, input logic [15:0] exp, input logic exp_chg,
                         input logic [W-1:0] post_bin, input int poke_at, input logic [W-1:0] poke_v);
    int lat;
    int busy_n;
    bit got;
    bus.i_valid = 1'b1;
    bus.i_bin   = v;
    @(posedge clk);
    #2;
    bus.i_valid = 1'b0;
    bus.i_bin   = post_bin;
    busy_n = bus.o_ready ? 0 : 1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      #2;
      if (lat == poke_at) begin
        bus.i_valid = 1'b1;
        bus.i_bin   = poke_v;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.o_done) got = 1'b1;
      else if (!bus.o_ready) busy_n++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("busy_cycles", 32'(busy_n), 32'(W));
    chk("result", 32'(dut_digits()), 32'(exp));
    chk("result_changed", 32'(bus.o_changed), 32'(exp_chg));
    chk("ready_in_done", 32'(bus.o_ready), 32'd1);
    last_done_t = $time;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1;
    int dones;
    logic [W-1:0] v;
    logic [15:0] e;
    bus.i_valid = 1'b0;
    bus.i_bin   = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready",  32'(bus.o_ready),  32'd1);
    chk("reset_busy",   32'(bus.o_busy),   32'd0);
    chk("reset_digits", 32'(dut_digits()), 32'h0000);
    chk("reset_done",   32'(bus.o_done),   32'd0);

    convert(13'd0,    16'h0000, 1'b0, 13'd77, 0, 13'd0);
    convert(13'd8191, 16'h8191, 1'b1, 13'd0,  0, 13'd0);
    convert(13'd1234, 16'h1234, 1'b1, 13'd5,  0, 13'd0);
    t1 = last_done_t;
    convert(13'd1234, 16'h1234, 1'b0, 13'd9,  0, 13'd0);
    chk("back_to_back_gap", 32'((last_done_t - t1) / 10), 32'd14);

    convert(13'd1000, 16'h1000, 1'b1, 13'd3,  5, 13'd5555);
    repeat (3) @(negedge clk);
    chk("ignored_poke_ready",  32'(bus.o_ready),  32'd1);
    chk("ignored_poke_digits", 32'(dut_digits()), 32'h1000);

    convert(13'd999,  16'h0999, 1'b1, 13'd7,  0, 13'd0);

    // Reset in the middle of a conversion.
    bus.i_valid = 1'b1;
    bus.i_bin   = 13'd4095;
    @(posedge clk);
    #2 bus.i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready",  32'(bus.o_ready),  32'd1);
    chk("abort_digits", 32'(dut_digits()), 32'h0000);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.o_done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    for (int i = 0; i < 30; i++) begin
      v = W'($urandom_range(0, (1 << W) - 1));
      e = to_bcd(int'(v));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert(v, e, (e != m_dig), W'($urandom), int'($urandom_range(0, 12)), W'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter: W, 13, binary input width; legal range 1..13, so every input fits in 4 BCD digits.
REQ-002 Port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: i_valid  input  1  request to convert i_bin.
REQ-005 Port: i_bin  input  W  unsigned binary value.
REQ-006 Port: o_ready  output  1  high when a request can be accepted.
REQ-007 Port: o_busy  output  1  conversion in progress; always equals ~o_ready.
REQ-008 Port: o_thousands, o_hundreds, o_tens, o_ones  output  4 each  registered BCD result digits.
REQ-009 Port: o_done  output  1  one-cycle pulse, result registers just updated.
REQ-010 Port: o_changed  output  1  one-cycle pulse with o_done when the new result differs from the previous one.

Function
REQ-011 FSM SHALL have two states: IDLE and SHIFT.
REQ-012 IDLE: o_ready=1; on an edge with i_valid=1, capture i_bin into a W-bit shift register, clear a 16-bit BCD scratch register, load the bit counter with W, and enter SHIFT.
REQ-013 IDLE with i_valid=0: hold all state; outputs unchanged.
REQ-014 SHIFT: o_ready=0; each edge performs one double-dabble step.
REQ-015 Double-dabble step: every scratch digit >=5 gets +3 (4-bit add, no carry out), then {scratch, shift reg} shifts left 1 bit, with the shift-reg MSB entering the scratch LSB.
REQ-016 SHIFT: the counter decrements each step; the step taken with counter==1 is the last one.
REQ-017 On the last-step edge, the module SHALL:
  - load the four output digits with the post-step scratch value;
  - assert o_done for the following cycle;
  - return to IDLE.
REQ-018 Latency: acceptance edge E0; result and o_done visible after edge E0+W (W=13: 13 clocks); throughput one result per W+1 clocks.
REQ-019 o_changed: asserted together with o_done when the new 16-bit result != the output registers' prior contents; otherwise 0.
REQ-020 i_valid while o_ready=0: ignored; no queuing; i_bin is not sampled.
REQ-021 i_bin may change freely after acceptance; the conversion uses only the captured value.
REQ-022 Back-to-back: in the cycle o_done=1, o_ready=1 too, and an i_valid in that cycle is accepted.
REQ-023 Output digits hold their last result indefinitely between conversions.
REQ-024 Every output digit SHALL always be in 0..9; maximum result 8,1,9,1 (8191).

Reset
REQ-025 i_rst_n=0 at a rising edge SHALL force the following:
  - state IDLE; counter 0; scratch 0; shift register 0;
  - all output digits 0; o_done=0; o_changed=0; o_ready=1; o_busy=0.
REQ-026 Reset during SHIFT aborts the conversion: no o_done and no output update; outputs read 0.
REQ-027 i_rst_n has priority over i_valid on the same edge.

Verification
REQ-028 Reset, then i_valid with i_bin=0 -> after 13 clocks: o_done=1, digits 0,0,0,0, o_changed=0.
REQ-029 i_bin=8191 -> after 13 clocks: digits 8,1,9,1, o_done=1, o_changed=1; o_ready=0 for exactly 13 cycles.
REQ-030 Convert 1234, then hold i_valid=1 with 1234 in the o_done cycle -> second result 1,2,3,4 with o_changed=0, completed 14 clocks after the first.
REQ-031 Accept 1000, pulse i_valid with 5555 at cycle 5 -> result 1,0,0,0; 5555 never converted.
REQ-032 Accept 4095, assert i_rst_n=0 at cycle 7 -> no o_done; digits 0,0,0,0; o_ready=1 after the reset edge.
REQ-033 Change i_bin from 999 to 7 one cycle after accepting 999 -> result 0,9,9,9.
